// File: rtl/jam_pkg.sv
// Shared definitions for the JAM cost server and the JAM engine.
package jam_pkg;

    localparam int N      = 8;
    localparam int IDX_W  = 3;
    localparam int COST_W = 7;
    localparam int ADDR_W = 2 * IDX_W;
    localparam int CNT_W  = 7;
    localparam int SUM_W  = COST_W + 6;

    localparam logic [CNT_W-1:0] LAST_WORD = 7'd63;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ARM   = 2'd1,
        SERVE = 2'd2
    } state_t;

    // Flat register-file address of matrix cell [row][col].
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [IDX_W-1:0] row,
                                                    input logic [IDX_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/jam_cost_server_if.sv
// Load stream and JAM-engine lookup signals between the server and its neighbours.
interface jam_cost_server_if;
    import jam_pkg::*;

    logic              load_valid;
    logic [COST_W-1:0] load_data;
    logic              load_ready;
    logic [IDX_W-1:0]  W;
    logic [IDX_W-1:0]  J;
    logic [COST_W-1:0] Cost;
    logic              Done;

    modport master (
        output load_valid, load_data, W, J, Done,
        input  load_ready, Cost
    );

    modport slave (
        input  load_valid, load_data, W, J, Done,
        output load_ready, Cost
    );
endinterface

// File: rtl/jam_cost_ram.sv
// NxN cost register file: one synchronous write port, one combinational read port.
module jam_cost_ram
    import jam_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [COST_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [COST_W-1:0] rdata_o
);

    logic [COST_W-1:0] mem_q [N*N];

    // Write one entry per accepted word; contents are never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jam_cost_server.sv
// Loads the 8x8 cost matrix, holds the JAM engine in reset until complete, then serves lookups.
module jam_cost_server
    import jam_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    jam_cost_server_if.slave   bus,
    output logic               jam_rst,
    output logic [SUM_W-1:0]   table_sum,
    output logic [CNT_W-1:0]   load_cnt
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              accept_s;
    logic              clear_s;
    logic [COST_W-1:0] rdata_s;

    // Words are only taken while loading; Done only matters while serving.
    assign accept_s = bus.load_valid && (state_q == EMPTY);
    assign clear_s  = bus.Done && (state_q == SERVE);

    jam_cost_ram u_ram (
        .clk     (CLK),
        .we_i    (accept_s),
        .waddr_i (cnt_q[ADDR_W-1:0]),
        .wdata_i (bus.load_data),
        .raddr_i (cell_addr(bus.W, bus.J)),
        .rdata_o (rdata_s)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill -> one arming cycle -> serve until Done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept_s && (cnt_q == LAST_WORD)) begin
                    state_d = ARM;
                end else begin
                    state_d = EMPTY;
                end
            end
            ARM: begin
                state_d = SERVE;
            end
            SERVE: begin
                if (bus.Done) begin
                    state_d = EMPTY;
                end else begin
                    state_d = SERVE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Outputs decoded from state; Cost is an unregistered read so it settles by the negedge.
    always_comb begin
        bus.load_ready = 1'b0;
        jam_rst        = 1'b1;
        bus.Cost       = {COST_W{1'b0}};
        case (state_q)
            EMPTY: begin
                bus.load_ready = 1'b1;
                jam_rst        = 1'b1;
            end
            ARM: begin
                bus.load_ready = 1'b0;
                jam_rst        = 1'b1;
            end
            SERVE: begin
                bus.load_ready = 1'b0;
                jam_rst        = 1'b0;
                bus.Cost       = rdata_s;
            end
            default: begin
                bus.load_ready = 1'b0;
                jam_rst        = 1'b1;
            end
        endcase
    end

    // Word counter and checksum next values: clear on Done, accumulate on accept.
    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (clear_s) begin
            cnt_d = {CNT_W{1'b0}};
            sum_d = {SUM_W{1'b0}};
        end else if (accept_s) begin
            cnt_d = cnt_q + 7'd1;
            sum_d = sum_q + {{(SUM_W-COST_W){1'b0}}, bus.load_data};
        end else begin
            cnt_d = cnt_q;
            sum_d = sum_q;
        end
    end

    // Word counter and checksum registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= {CNT_W{1'b0}};
            sum_q <= {SUM_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

    assign load_cnt  = cnt_q;
    assign table_sum = sum_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: table-driven full loads, corner sequences, random run.
module tb_jam_cost_server;
    import jam_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        jam_rst;
    logic [12:0] table_sum;
    logic [6:0]  load_cnt;

    jam_cost_server_if bus();

    jam_cost_server dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus.slave),
        .jam_rst   (jam_rst),
        .table_sum (table_sum),
        .load_cnt  (load_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: matrix contents, words loaded, running sum, phase (0 load, 1 arm, 2 serve).
    int m_tbl [64];
    int m_cnt, m_sum, m_phase;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int kind;
        bit gap;
        int exp_sum;
        int exp_c25;
        int exp_c77;
    } rec_t;

    rec_t recs [4];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int pat(input int kind, input int i);
        case (kind)
            0:       return (i * 5 + 3) % 128;
            1:       return 1;
            default: return ((i / 8) + (i % 8)) % 8;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_sum   = 0;
        m_phase = 0;
    endtask

    // Apply the loader / server rules to the inputs present at this edge.
    task automatic model_edge();
        if (m_phase == 0) begin
            if (bus.load_valid) begin
                m_tbl[m_cnt] = int'(bus.load_data);
                m_sum += int'(bus.load_data);
                m_cnt++;
                if (m_cnt == 64) m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            if (bus.Done) begin
                m_phase = 0;
                m_cnt   = 0;
                m_sum   = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("load_ready", int'(bus.load_ready), (m_phase == 0) ? 1 : 0);
        chk("jam_rst",    int'(jam_rst),        (m_phase == 2) ? 0 : 1);
        chk("load_cnt",   int'(load_cnt),       m_cnt);
        chk("table_sum",  int'(table_sum),      m_sum);
        chk("cost",       int'(bus.Cost),
            (m_phase == 2) ? m_tbl[int'(bus.W) * 8 + int'(bus.J)] : 0);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    // Stream words of a pattern until limit words are loaded (bounded).
    task automatic load_words(input int kind, input bit gap, input int limit);
        int n = 0;
        bus.W = 3'd7;
        bus.J = 3'd7;
        while (m_phase == 0 && m_cnt < limit && n < 300) begin
            bus.load_valid = gap ? ((n % 2) == 0) : 1'b1;
            bus.load_data  = 7'(pat(kind, m_cnt));
            cycle();
            n++;
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic run_record(input rec_t r, input bit with_word);
        load_words(r.kind, r.gap, 64);
        chk("arm_jam_rst", int'(jam_rst), 1);
        chk("arm_ready",   int'(bus.load_ready), 0);
        chk("arm_cnt",     int'(load_cnt), 64);
        cycle();
        chk("serve_jam_rst", int'(jam_rst), 0);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                bus.W = 3'(w);
                bus.J = 3'(j);
                cycle();
            end
        end
        bus.W = 3'd2; bus.J = 3'd5; #1;
        chk("cost_2_5", int'(bus.Cost), r.exp_c25);
        bus.W = 3'd7; bus.J = 3'd7; #1;
        chk("cost_7_7", int'(bus.Cost), r.exp_c77);
        chk("sum_const", int'(table_sum), r.exp_sum);
        bus.Done       = 1'b1;
        bus.load_valid = with_word;
        bus.load_data  = 7'd99;
        cycle();
        bus.Done       = 1'b0;
        bus.load_valid = 1'b0;
        chk("done_jam_rst", int'(jam_rst), 1);
        chk("done_cnt",     int'(load_cnt), 0);
        chk("done_sum",     int'(table_sum), 0);
        chk("done_ready",   int'(bus.load_ready), 1);
        cycle();
        chk("dropped_word_cnt", int'(load_cnt), 0);
    endtask

    initial begin
        recs[0] = '{kind: 0, gap: 1'b0, exp_sum: 3616, exp_c25: 108, exp_c77: 62};
        recs[1] = '{kind: 0, gap: 1'b1, exp_sum: 3616, exp_c25: 108, exp_c77: 62};
        recs[2] = '{kind: 1, gap: 1'b0, exp_sum: 64,   exp_c25: 1,   exp_c77: 1};
        recs[3] = '{kind: 2, gap: 1'b0, exp_sum: 224,  exp_c25: 7,   exp_c77: 6};

        RST            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = 7'd0;
        bus.W          = 3'd7;
        bus.J          = 3'd7;
        bus.Done       = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ready",   int'(bus.load_ready), 1);
        chk("rst_jam_rst", int'(jam_rst), 1);
        chk("rst_cnt",     int'(load_cnt), 0);
        chk("rst_sum",     int'(table_sum), 0);
        chk("rst_cost",    int'(bus.Cost), 0);
        RST = 1'b0;

        for (int r = 0; r < 4; r++) begin
            run_record(recs[r], (r == 0));
        end

        // Asynchronous reset in the middle of a load.
        load_words(0, 1'b0, 30);
        chk("pre_rst_cnt", int'(load_cnt), 30);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_cnt",     int'(load_cnt), 0);
        chk("mid_rst_jam_rst", int'(jam_rst), 1);
        chk("mid_rst_sum",     int'(table_sum), 0);
        #1 RST = 1'b0;
        model_reset();
        run_record(recs[0], 1'b0);

        // Random traffic against the reference model.
        for (int k = 0; k < 1500; k++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_data  = 7'($urandom_range(0, 127));
            bus.W          = 3'($urandom_range(0, 7));
            bus.J          = 3'($urandom_range(0, 7));
            bus.Done       = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
